// File: rtl/yuv_frame_assembler_if.sv
// Handshake buses of the YUV frame assembler: IDCT row input and raster pixel output.
interface yuv_row_if #(
  parameter int unsigned COEF_SIZE = 12
);
  logic                   row_valid;
  logic                   row_ready;
  logic [8*COEF_SIZE-1:0] row_data;

  modport master (output row_valid, output row_data, input row_ready);
  modport slave  (input row_valid, input row_data, output row_ready);
endinterface

interface yuv_pix_if #(
  parameter int unsigned PIXEL_SIZE = 8
);
  logic                  pix_valid;
  logic                  pix_ready;
  logic [PIXEL_SIZE-1:0] pix_y;
  logic [PIXEL_SIZE-1:0] pix_cb;
  logic [PIXEL_SIZE-1:0] pix_cr;
  logic                  frame_done;

  modport master (output pix_valid, output pix_y, output pix_cb, output pix_cr,
                  output frame_done, input pix_ready);
  modport slave  (input pix_valid, input pix_y, input pix_cb, input pix_cr,
                  input frame_done, output pix_ready);
endinterface

// File: rtl/yuv_frame_assembler.sv
// Collects clamped 8x8-block IDCT rows into Y/Cb/Cr frame memories, then
// streams the completed frame out in raster order.
module yuv_frame_assembler #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned HEIGHT     = 32,
  parameter int unsigned PIXEL_SIZE = 8,
  parameter int unsigned COEF_SIZE  = 12
) (
  input  logic      clock,
  input  logic      reset,
  yuv_row_if.slave  i_row,
  yuv_pix_if.master o_pix
);

  localparam int unsigned LANES  = 8;
  localparam int unsigned NPIX   = WIDTH * HEIGHT;
  localparam int unsigned ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned BX_N   = WIDTH / 8;
  localparam int unsigned BY_N   = HEIGHT / 8;
  localparam int unsigned BX_W   = (BX_N > 1) ? $clog2(BX_N) : 1;
  localparam int unsigned BY_W   = (BY_N > 1) ? $clog2(BY_N) : 1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_PRIME = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [2:0]            r_row;
  logic [1:0]            r_comp;
  logic [BX_W-1:0]       r_bx;
  logic [BY_W-1:0]       r_by;
  logic [ADDR_W-1:0]     r_raster;

  logic                  r_row_ready;
  logic                  r_pix_valid;
  logic [PIXEL_SIZE-1:0] r_pix_y;
  logic [PIXEL_SIZE-1:0] r_pix_cb;
  logic [PIXEL_SIZE-1:0] r_pix_cr;

  logic [PIXEL_SIZE-1:0] r_mem_y  [NPIX];
  logic [PIXEL_SIZE-1:0] r_mem_cb [NPIX];
  logic [PIXEL_SIZE-1:0] r_mem_cr [NPIX];

  logic                  w_accept;
  logic                  w_last_row;
  logic                  w_handshake;
  logic                  w_last_pix;
  logic                  w_rd_en;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic [ADDR_W-1:0]     w_wr_base;
  logic                  w_frame_done_c;
  logic [PIXEL_SIZE-1:0] w_lane_px [LANES];

  // Saturate a two's-complement lane into the unsigned pixel range.
  function automatic logic [PIXEL_SIZE-1:0] clamp_lane(input logic [COEF_SIZE-1:0] v);
    if (v[COEF_SIZE-1]) begin
      return '0;
    end else if (|v[COEF_SIZE-2:PIXEL_SIZE]) begin
      return '1;
    end else begin
      return v[PIXEL_SIZE-1:0];
    end
  endfunction

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_lane_px[k] = clamp_lane(i_row.row_data[(LANES-k)*COEF_SIZE-1 -: COEF_SIZE]);
    end
  end

  // First pixel of the current row inside the raster-ordered frame.
  assign w_wr_base = ADDR_W'((32'(r_by) * 8 + 32'(r_row)) * WIDTH + 32'(r_bx) * 8);

  assign w_last_row = (r_row == 3'd7) && (r_comp == 2'd2) &&
                      (r_bx == BX_W'(BX_N - 1)) && (r_by == BY_W'(BY_N - 1));
  assign w_last_pix = (r_raster == ADDR_W'(NPIX - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_raster;
    case (r_state)
      S_FILL: begin
        w_accept = i_row.row_valid && r_row_ready;
        if (w_accept && w_last_row) begin
          w_next_state = S_PRIME;
        end
      end
      S_PRIME: begin
        w_rd_en      = 1'b1;
        w_rd_addr    = '0;
        w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        w_handshake = r_pix_valid && o_pix.pix_ready;
        if (w_handshake) begin
          if (w_last_pix) begin
            w_next_state = S_FILL;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_raster + 1'b1;
          end
        end
      end
      default: begin
        w_next_state = S_FILL;
      end
    endcase
  end

  assign w_frame_done_c = w_handshake && w_last_pix;

  // Block-order counter chain (row fastest) plus raster read pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row       <= '0;
      r_comp      <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_raster    <= '0;
      r_row_ready <= 1'b0;
    end else begin
      r_row_ready <= (w_next_state == S_FILL);
      if (w_accept) begin
        if (r_row == 3'd7) begin
          r_row <= '0;
          if (r_comp == 2'd2) begin
            r_comp <= '0;
            if (r_bx == BX_W'(BX_N - 1)) begin
              r_bx <= '0;
              if (r_by == BY_W'(BY_N - 1)) begin
                r_by <= '0;
              end else begin
                r_by <= r_by + 1'b1;
              end
            end else begin
              r_bx <= r_bx + 1'b1;
            end
          end else begin
            r_comp <= r_comp + 1'b1;
          end
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
      if (w_handshake) begin
        r_raster <= w_last_pix ? '0 : r_raster + 1'b1;
      end
    end
  end

  // Output pixel registers reload only on prime or handshake, so they hold under backpressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pix_valid <= 1'b0;
      r_pix_y     <= '0;
      r_pix_cb    <= '0;
      r_pix_cr    <= '0;
    end else begin
      if (w_rd_en) begin
        r_pix_valid <= 1'b1;
        r_pix_y     <= r_mem_y[w_rd_addr];
        r_pix_cb    <= r_mem_cb[w_rd_addr];
        r_pix_cr    <= r_mem_cr[w_rd_addr];
      end else if (w_handshake) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

  // Frame memories are intentionally left uncleared by reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int k = 0; k < LANES; k++) begin
        case (r_comp)
          2'd0:    r_mem_y[w_wr_base + ADDR_W'(k)]  <= w_lane_px[k];
          2'd1:    r_mem_cb[w_wr_base + ADDR_W'(k)] <= w_lane_px[k];
          default: r_mem_cr[w_wr_base + ADDR_W'(k)] <= w_lane_px[k];
        endcase
      end
    end
  end

  assign i_row.row_ready  = r_row_ready;
  assign o_pix.pix_valid  = r_pix_valid;
  assign o_pix.pix_y      = r_pix_y;
  assign o_pix.pix_cb     = r_pix_cb;
  assign o_pix.pix_cr     = r_pix_cr;
  assign o_pix.frame_done = w_frame_done_c;

endmodule

// File: tb/tb_yuv_frame_assembler.sv
// Scoreboard bench for yuv_frame_assembler: a reference model of the filled
// frame feeds an expected-pixel queue that is drained against the DUT output.
module tb_yuv_frame_assembler;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int NPIX = W * H;

  logic clk;
  logic rst_n;

  yuv_row_if #(.COEF_SIZE(12)) rif ();
  yuv_pix_if #(.PIXEL_SIZE(8)) pif ();

  yuv_frame_assembler #(
    .WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(8), .COEF_SIZE(12)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .i_row(rif),
    .o_pix(pif)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] sb_q [$];
  logic [7:0]  m_y  [NPIX];
  logic [7:0]  m_cb [NPIX];
  logic [7:0]  m_cr [NPIX];
  logic [7:0]  obs_y  [NPIX];
  logic [7:0]  obs_cb [NPIX];
  logic [7:0]  obs_cr [NPIX];
  int          pix_cnt = 0;
  int          fd_cnt  = 0;
  logic        hs;

  logic [11:0] clamp_in  [8] = '{12'h7FF, 12'h800, 12'h0FF, 12'h100,
                                 12'h000, 12'hFFF, 12'h080, 12'h0FE};
  logic [7:0]  clamp_exp [8] = '{8'd255, 8'd0, 8'd255, 8'd255,
                                 8'd0, 8'd0, 8'd128, 8'd254};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_clamp(input logic [11:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  function automatic logic [11:0] lane_val(input int mode, input int by, input int bx,
                                           input int c, input int r, input int k);
    case (mode)
      0:       return (by == 0 && bx == 0 && c == 0 && r == 0) ? clamp_in[k] : 12'h000;
      1:       return 12'(by * 64 + bx * 16 + c * 8 + r);
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // Output monitor: pops one expected triple per handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      pix_cnt = 0;
    end else begin
      hs = pif.pix_valid && pif.pix_ready;
      if (hs || pif.frame_done)
        check("frame_done", 32'(pif.frame_done), 32'(hs && (pix_cnt == NPIX - 1)));
      if (pif.frame_done) fd_cnt++;
      if (hs) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          check("pixel", 32'({pif.pix_y, pif.pix_cb, pif.pix_cr}), 32'(sb_q.pop_front()));
        end
        obs_y[pix_cnt]  = pif.pix_y;
        obs_cb[pix_cnt] = pif.pix_cb;
        obs_cr[pix_cnt] = pif.pix_cr;
        pix_cnt = (pix_cnt == NPIX - 1) ? 0 : pix_cnt + 1;
      end
    end
  end

  task automatic send_row(input logic [95:0] d);
    int guard = 0;
    rif.row_valid = 1'b1;
    rif.row_data  = d;
    while (!rif.row_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!rif.row_ready) check("row_ready_timeout", 32'(rif.row_ready), 32'd1);
    @(posedge clk); #1;
    rif.row_valid = 1'b0;
  endtask

  task automatic fill_frame(input int mode, input int gap);
    logic [95:0] d;
    logic [11:0] lv;
    int          addr;
    for (int by = 0; by < H / 8; by++)
      for (int bx = 0; bx < W / 8; bx++)
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
              lv = lane_val(mode, by, bx, c, r, k);
              d[95 - 12 * k -: 12] = lv;
              addr = (by * 8 + r) * W + bx * 8 + k;
              if (c == 0) m_y[addr] = ref_clamp(lv);
              else if (c == 1) m_cb[addr] = ref_clamp(lv);
              else m_cr[addr] = ref_clamp(lv);
            end
            send_row(d);
            if (gap > 0 && !(by == H / 8 - 1 && bx == W / 8 - 1 && c == 2 && r == 7))
              repeat (gap) begin @(posedge clk); #1; end
          end
    for (int i = 0; i < NPIX; i++) sb_q.push_back({m_y[i], m_cb[i], m_cr[i]});
    check("prime_row_ready", 32'(rif.row_ready), 32'd0);
    check("prime_pix_valid", 32'(pif.pix_valid), 32'd0);
    @(posedge clk); #1;
    check("first_pix_valid", 32'(pif.pix_valid), 32'd1);
  endtask

  task automatic drain_frame(input int stall_at, input int stop_at);
    int          n = 0;
    int          guard = 0;
    logic [23:0] held;
    pif.pix_ready = 1'b1;
    while (n < NPIX && n != stop_at && guard < 4 * NPIX) begin
      if (pif.pix_valid) begin
        if (n == stall_at) begin
          pif.pix_ready = 1'b0;
          held = {pif.pix_y, pif.pix_cb, pif.pix_cr};
          repeat (5) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(pif.pix_valid), 32'd1);
            check("stall_hold", 32'({pif.pix_y, pif.pix_cb, pif.pix_cr}), 32'(held));
          end
          pif.pix_ready = 1'b1;
        end
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 4 * NPIX) check("drain_timeout", 32'(n), 32'(NPIX));
  endtask

  task automatic end_of_frame_checks();
    check("post_pix_valid", 32'(pif.pix_valid), 32'd0);
    check("post_row_ready", 32'(rif.row_ready), 32'd1);
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    pif.pix_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    rif.row_valid = 1'b0;
    rif.row_data  = '0;
    pif.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_ready", 32'(rif.row_ready), 32'd0);
    check("rst_pix_valid", 32'(pif.pix_valid), 32'd0);
    check("rst_pix", 32'({pif.pix_y, pif.pix_cb, pif.pix_cr}), 32'd0);
    check("rst_frame_done", 32'(pif.frame_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_row_ready", 32'(rif.row_ready), 32'd1);

    // Clamp frame
    fill_frame(0, 0);
    fd_cnt = 0;
    drain_frame(-1, -1);
    end_of_frame_checks();
    for (int i = 0; i < 8; i++) check("clamp_px", 32'(obs_y[i]), 32'(clamp_exp[i]));

    // Block-mapping frame with backpressure at raster 10
    fill_frame(1, 0);
    fd_cnt = 0;
    drain_frame(10, -1);
    end_of_frame_checks();
    check("map_y_x8y0", 32'(obs_y[8]), 32'd16);
    check("map_cb_x8y0", 32'(obs_cb[8]), 32'd24);
    check("map_cr_x8y0", 32'(obs_cr[8]), 32'd32);
    check("map_y_x0y9", 32'(obs_y[9 * W]), 32'd65);

    // Same mapping data with 3-cycle input gaps
    fill_frame(1, 3);
    fd_cnt = 0;
    drain_frame(-1, -1);
    end_of_frame_checks();
    check("gap_y_x0y9", 32'(obs_y[9 * W]), 32'd65);

    // Random frame, reset in the middle of the drain
    fill_frame(2, 0);
    drain_frame(-1, 500);
    check("pre_rst_valid", 32'(pif.pix_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_pix_valid", 32'(pif.pix_valid), 32'd0);
    check("midrst_row_ready", 32'(rif.row_ready), 32'd0);
    sb_q.delete();
    pif.pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_rel_ready", 32'(rif.row_ready), 32'd1);

    // Fresh random frame after the abandoned one
    fill_frame(2, 0);
    fd_cnt = 0;
    drain_frame(-1, -1);
    end_of_frame_checks();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/yuv_frame_assembler.md
Name: yuv_frame_assembler

Overview:
- Decoder-side counterpart of the encoder pixel buffer. Accepts 96-bit IDCT row words (8 lanes x 12-bit) in 8x8-block order for Y, Cb and Cr.
- Clamps each lane to 8 bits and writes it into per-component frame memories at block-mapped addresses.
- Once a full frame is assembled, streams the frame out in raster order, one Y/Cb/Cr pixel triple per handshake, to the display/output writer.

Parameters:
- WIDTH, 32, frame width in pixels (multiple of 8)
- HEIGHT, 32, frame height in pixels (multiple of 8)
- PIXEL_SIZE, 8, output pixel width
- COEF_SIZE, 12, signed lane width in row_data

Ports:
- clock  input  1  single system clock, all logic on posedge
- reset  input  1  asynchronous, active-low reset
- row_valid  input  1  row_data holds a valid IDCT row
- row_ready  output  1  block accepts a row this cycle
- row_data  input  96  lane k (k=0..7) at [95-12k:84-12k], two's complement; lane 0 = leftmost pixel
- pix_valid  output  1  pix_y/pix_cb/pix_cr valid
- pix_ready  input  1  downstream accepts the current pixel
- pix_y  output  8  luma of current raster pixel
- pix_cb  output  8  Cb of current raster pixel
- pix_cr  output  8  Cr of current raster pixel
- frame_done  output  1  one-cycle pulse on the last pixel handshake

Behaviour:
- Reset (reset=0, async):
  - state=FILL; all counters 0.
  - row_ready=0 while reset is asserted; pix_valid=0, pix_y/cb/cr=0, frame_done=0.
  - Memories are not cleared.
- Storage: three arrays of WIDTH*HEIGHT x PIXEL_SIZE (Y, Cb, Cr), 4:4:4.
- FILL state:
  - row_ready=1. A row is accepted when row_valid && row_ready.
  - Input order, innermost first:
    - row r (0..7)
    - component c (0=Y, 1=Cb, 2=Cr)
    - block column bx (0..WIDTH/8-1)
    - block row by (0..HEIGHT/8-1)
  - Accepted row writes all 8 lanes in the same clock edge to mem_c[(by*8+r)*WIDTH + bx*8 + k].
  - Clamp per lane: value<0 -> 0; value>255 -> 255; otherwise the low 8 bits.
  - The counter chain advances only on accept. A cycle without accept changes nothing.
  - Accepting the last row (r=7, c=2, last bx, last by; 384 rows at defaults) -> PRIME next cycle. row_ready drops in that same cycle.
- PRIME state (1 cycle):
  - row_ready=0.
  - Load output registers from address raster=0; pix_valid=1 from the next cycle -> DRAIN.
  - Latency from last row accept to pix_valid=1 is 2 cycles.
- DRAIN state:
  - row_ready=0; row_valid is ignored and no write occurs.
  - Outputs are held stable while pix_valid && !pix_ready.
  - On handshake, the raster counter increments and the registers reload from the new address the next cycle.
  - On handshake at raster=WIDTH*HEIGHT-1:
    - frame_done=1 for that cycle.
    - Next cycle: pix_valid=0, state=FILL, row_ready=1, all counters 0.
- No simultaneous read/write is possible; FILL and DRAIN are exclusive, which is the frame boundary rule.
- Reset mid-frame: the partial frame is abandoned. After release, the block restarts at FILL row 0; stale memory contents are overwritten by the next fill.

Test Plan:
- Clamp: first Y row lanes 0x7FF, 0x800, 0x0FF, 0x100, 0x000, 0xFFF, 0x080, 0x0FE, remaining rows 0, complete fill -> raster pixels 0..7 pix_y = 255, 0, 255, 255, 0, 0, 128, 254.
- Block mapping: every lane of each row = {by, bx, c, r} encoded (by*64+bx*16+c*8+r) -> raster (x=8, y=0) gives pix_y=16, pix_cb=24, pix_cr=32; (x=0, y=9) gives pix_y=65.
- Input gaps: deassert row_valid for 3 cycles between rows -> no counter advance; memory contents are identical to the gap-free run.
- Backpressure: in DRAIN hold pix_ready=0 for 5 cycles at raster=10 -> pix_valid=1 and pixel values unchanged; raster pixel 10 is emitted exactly once.
- Frame end: 1024th handshake -> frame_done high exactly 1 cycle; next cycle row_ready=1, pix_valid=0. Second frame with new data streams new values.
- Reset mid-DRAIN at raster=500 -> pix_valid=0 and row_ready=0 immediately; after release row_ready=1 and the fill restarts at row 0.
